db_read_ctrl: RTL and testbench

Parametrised read-side controller for the USB endpoint data buffer. It produces read strobes, a registered read address and a wrap-extended read pointer for the buffer RAM. It keeps a committed packet-start pointer so an unacknowledged packet can be replayed after a NAK or timeout. It sits between the TX/RX protocol FSMs and the buffer storage; occupancy logic uses `commit_ptr` to protect uncommitted data from overwrite.

---
 rtl/db_read_ctrl_if.sv | 38 +++
 rtl/db_read_ctrl.sv | 122 ++++++++++++
 tb/tb_db_read_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_read_ctrl_if.sv
// Handshake bundle between the protocol FSMs and the buffer read controller.
// master drives requests/packet control; slave is the read controller.
interface db_read_ctrl_if #(
  parameter int AW = 6
);
  logic          get_tx_data;
  logic          get_rx_data;
  logic [AW:0]   buff_occ;
  logic          clear;
  logic          flush;
  logic          pkt_done;
  logic          ack;
  logic          retry;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [AW:0]   read_ptr;
  logic [AW:0]   commit_ptr;
  logic [AW:0]   pkt_len;
  logic          busy;
  logic          underrun;
  logic          protocol_err;

  modport master (
    output get_tx_data, get_rx_data, buff_occ,
    output clear, flush, pkt_done, ack, retry,
    input  read_en, read_addr, read_ptr,
    input  commit_ptr, pkt_len, busy,
    input  underrun, protocol_err
  );

  modport slave (
    input  get_tx_data, get_rx_data, buff_occ,
    input  clear, flush, pkt_done, ack, retry,
    output read_en, read_addr, read_ptr,
    output commit_ptr, pkt_len, busy,
    output underrun, protocol_err
  );
endinterface

// File: rtl/db_read_ctrl.sv
// USB endpoint buffer read controller: read strobes, wrap-extended
// read pointer and a committed packet-start pointer for NAK replay.
module db_read_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  db_read_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("db_read_ctrl: DEPTH must be a power of two >= 4");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   cptr_q, cptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ren_q, ren_d;
  logic          unr_q, unr_d;
  logic          perr_q, perr_d;

  logic req;
  logic has_data;
  logic clr;

  assign req      = bus.get_tx_data | bus.get_rx_data;
  assign has_data = (bus.buff_occ != '0);
  assign clr      = bus.clear | bus.flush;

  // Only the highest-priority event acts; pkt_done may also carry a read.
  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    cptr_d  = cptr_q;
    addr_d  = addr_q;
    ren_d   = 1'b0;
    unr_d   = 1'b0;
    perr_d  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      rptr_d  = '0;
      cptr_d  = '0;
      addr_d  = '0;
    end else if (bus.retry) begin
      if (state_q == HOLD) begin
        rptr_d  = cptr_q;
        state_d = IDLE;
      end else begin
        perr_d = 1'b1;
      end
    end else if (bus.ack) begin
      if (state_q == HOLD) begin
        cptr_d  = rptr_q;
        state_d = IDLE;
      end else begin
        perr_d = 1'b1;
      end
    end else if (bus.pkt_done) begin
      if (state_q == ACTIVE) begin
        state_d = HOLD;
        if (req && has_data) begin
          ren_d  = 1'b1;
          addr_d = rptr_q[AW-1:0];
          rptr_d = rptr_q + 1'b1;
        end
      end else begin
        perr_d = 1'b1;
      end
    end else if (req) begin
      if (state_q == HOLD) begin
        perr_d = 1'b1;
      end else if (!has_data) begin
        unr_d = 1'b1;
      end else begin
        ren_d   = 1'b1;
        addr_d  = rptr_q[AW-1:0];
        rptr_d  = rptr_q + 1'b1;
        state_d = ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rptr_q  <= '0;
      cptr_q  <= '0;
      addr_q  <= '0;
      ren_q   <= 1'b0;
      unr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      cptr_q  <= cptr_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      unr_q   <= unr_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.read_en      = ren_q;
  assign bus.read_addr    = addr_q;
  assign bus.read_ptr     = rptr_q;
  assign bus.commit_ptr   = cptr_q;
  assign bus.pkt_len      = rptr_q - cptr_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.underrun     = unr_q;
  assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_db_read_ctrl.sv
// Self-checking bench for db_read_ctrl: directed scenarios plus a
// randomized run against an integer reference model.
module tb_db_read_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int MODV  = 2 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  db_read_ctrl_if #(.AW(AW)) bus ();

  db_read_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain integers, modes as names
  int m_rp, m_cp, m_addr;
  int m_mode;
  bit m_ren, m_unr, m_perr;
  localparam int M_IDLE = 0, M_READING = 1, M_WAITACK = 2;

  function automatic void model_reset();
    m_rp = 0; m_cp = 0; m_addr = 0; m_mode = M_IDLE;
    m_ren = 0; m_unr = 0; m_perr = 0;
  endfunction

  function automatic void model_read();
    m_ren  = 1;
    m_addr = m_rp % DEPTH;
    m_rp   = (m_rp + 1) % MODV;
  endfunction

  function automatic void model_step(bit tx, bit rx, int occ, bit clr,
                                     bit fl, bit done, bit ak, bit rt);
    bit want;
    want = tx | rx;
    m_ren = 0; m_unr = 0; m_perr = 0;
    if (clr || fl) begin
      m_rp = 0; m_cp = 0; m_addr = 0; m_mode = M_IDLE;
    end else if (rt) begin
      if (m_mode == M_WAITACK) begin m_rp = m_cp; m_mode = M_IDLE; end
      else m_perr = 1;
    end else if (ak) begin
      if (m_mode == M_WAITACK) begin m_cp = m_rp; m_mode = M_IDLE; end
      else m_perr = 1;
    end else if (done) begin
      if (m_mode == M_READING) begin
        m_mode = M_WAITACK;
        if (want && occ != 0) model_read();
      end else m_perr = 1;
    end else if (want) begin
      if (m_mode == M_WAITACK) m_perr = 1;
      else if (occ == 0) m_unr = 1;
      else begin model_read(); m_mode = M_READING; end
    end
  endfunction

  task automatic idle_inputs();
    bus.get_tx_data = 0; bus.get_rx_data = 0; bus.buff_occ = '0;
    bus.clear = 0; bus.flush = 0; bus.pkt_done = 0;
    bus.ack = 0; bus.retry = 0;
  endtask

  // drive one cycle of inputs, clock it, advance model, sample at +1
  task automatic cycle(bit tx, bit rx, int occ, bit clr, bit fl,
                       bit done, bit ak, bit rt);
    bus.get_tx_data = tx; bus.get_rx_data = rx;
    bus.buff_occ = (AW+1)'(occ);
    bus.clear = clr; bus.flush = fl; bus.pkt_done = done;
    bus.ack = ak; bus.retry = rt;
    @(posedge clk);
    model_step(tx, rx, occ, clr, fl, done, ak, rt);
    #1;
    idle_inputs();
  endtask

  task automatic rd(int occ);
    cycle(1, 0, occ, 0, 0, 0, 0, 0);
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.read_en, bus.read_addr, bus.read_ptr, bus.commit_ptr,
         bus.pkt_len, bus.busy, bus.underrun, bus.protocol_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%0b addr=%0d rp=%0d cp=%0d len=%0d busy=%0b un=%0b pe=%0b, required all 0",
               bus.read_en, bus.read_addr, bus.read_ptr, bus.commit_ptr,
               bus.pkt_len, bus.busy, bus.underrun, bus.protocol_err);
    end
  endtask

  task automatic test_basic_read();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rd(3);
      n_checks++;
      if (bus.read_en !== 1'b1 || bus.read_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL basic_read%0d: en=%0b addr=%0d, required en=1 addr=%0d",
                 i, bus.read_en, bus.read_addr, i);
      end
    end
    n_checks++;
    if (bus.read_ptr !== 7'd3 || bus.busy !== 1'b1 || bus.pkt_len !== 7'd3) begin
      n_fail++;
      $display("FAIL basic_state: rp=%0d busy=%0b len=%0d, required 3 1 3",
               bus.read_ptr, bus.busy, bus.pkt_len);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    rd(0);
    n_checks++;
    if (bus.read_en !== 1'b0 || bus.underrun !== 1'b1 ||
        bus.read_ptr !== 7'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_pulse: en=%0b un=%0b rp=%0d busy=%0b, required 0 1 0 0",
               bus.read_en, bus.underrun, bus.read_ptr, bus.busy);
    end
    nop();
    n_checks++;
    if (bus.underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_once: un=%0b, required 0", bus.underrun);
    end
  endtask

  task automatic test_retry_replay();
    do_reset();
    for (int i = 0; i < 5; i++) rd(8);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (bus.read_ptr !== 7'd0 || bus.commit_ptr !== 7'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_rewind: rp=%0d cp=%0d busy=%0b, required 0 0 0",
               bus.read_ptr, bus.commit_ptr, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      rd(8);
      n_checks++;
      if (bus.read_en !== 1'b1 || bus.read_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL replay%0d: en=%0b addr=%0d, required 1 %0d",
                 i, bus.read_en, bus.read_addr, i);
      end
    end
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (bus.commit_ptr !== 7'd5 || bus.pkt_len !== 7'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_commit: cp=%0d len=%0d busy=%0b, required 5 0 0",
               bus.commit_ptr, bus.pkt_len, bus.busy);
    end
  endtask

  task automatic test_wrap();
    int exp_a[4];
    exp_a = '{62, 63, 0, 1};
    do_reset();
    for (int i = 0; i < 126; i++) rd(DEPTH);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (bus.read_ptr !== 7'd126 || bus.commit_ptr !== 7'd126) begin
      n_fail++;
      $display("FAIL wrap_preload: rp=%0d cp=%0d, required 126 126",
               bus.read_ptr, bus.commit_ptr);
    end
    for (int i = 0; i < 4; i++) begin
      rd(10);
      n_checks++;
      if (bus.read_en !== 1'b1 || bus.read_addr !== AW'(exp_a[i])) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: en=%0b addr=%0d, required 1 %0d",
                 i, bus.read_en, bus.read_addr, exp_a[i]);
      end
    end
    n_checks++;
    if (bus.read_ptr !== 7'd2 || bus.pkt_len !== 7'd4) begin
      n_fail++;
      $display("FAIL wrap_ptr: rp=%0d len=%0d, required 2 4",
               bus.read_ptr, bus.pkt_len);
    end
  endtask

  task automatic test_hold_ack_priority();
    do_reset();
    rd(4);
    rd(4);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 4, 0, 0, 0, 1, 0);
    n_checks++;
    if (bus.read_en !== 1'b0 || bus.protocol_err !== 1'b0 ||
        bus.commit_ptr !== 7'd2 || bus.read_ptr !== 7'd2 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ack_read: en=%0b pe=%0b cp=%0d rp=%0d busy=%0b, required 0 0 2 2 0",
               bus.read_en, bus.protocol_err, bus.commit_ptr, bus.read_ptr, bus.busy);
    end
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (bus.protocol_err !== 1'b1 || bus.commit_ptr !== 7'd2) begin
      n_fail++;
      $display("FAIL idle_ack_err: pe=%0b cp=%0d, required 1 2",
               bus.protocol_err, bus.commit_ptr);
    end
    nop();
    n_checks++;
    if (bus.protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_once: pe=%0b, required 0", bus.protocol_err);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 9; i++) rd(20);
    n_checks++;
    if (bus.read_ptr !== 7'd9) begin
      n_fail++;
      $display("FAIL flush_pre: rp=%0d, required 9", bus.read_ptr);
    end
    cycle(1, 0, 20, 0, 1, 0, 0, 0);
    n_checks++;
    if (bus.read_ptr !== 7'd0 || bus.commit_ptr !== 7'd0 || bus.read_en !== 1'b0 ||
        bus.read_addr !== 6'd0 || bus.busy !== 1'b0 || bus.protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: rp=%0d cp=%0d en=%0b addr=%0d busy=%0b pe=%0b, required all 0",
               bus.read_ptr, bus.commit_ptr, bus.read_en, bus.read_addr,
               bus.busy, bus.protocol_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) rd(20);
    #2;
    rst = 1;
    #1;
    n_checks++;
    if (bus.read_ptr !== 7'd0 || bus.commit_ptr !== 7'd0 || bus.read_en !== 1'b0 ||
        bus.read_addr !== 6'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rp=%0d cp=%0d en=%0b addr=%0d busy=%0b, required all 0",
               bus.read_ptr, bus.commit_ptr, bus.read_en, bus.read_addr, bus.busy);
    end
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit tx, rx, clr, fl, dn, ak, rt;
    int occ;
    int exp_len;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tx  = ($urandom_range(99) < 55);
      rx  = ($urandom_range(99) < 25);
      occ = ($urandom_range(99) < 20) ? 0 : int'($urandom_range(DEPTH, 1));
      clr = ($urandom_range(99) < 2);
      fl  = ($urandom_range(99) < 2);
      dn  = ($urandom_range(99) < 10);
      ak  = ($urandom_range(99) < 8);
      rt  = ($urandom_range(99) < 6);
      cycle(tx, rx, occ, clr, fl, dn, ak, rt);
      exp_len = (m_rp - m_cp + MODV) % MODV;
      n_checks++;
      if (bus.read_en !== m_ren || bus.read_addr !== AW'(m_addr) ||
          bus.read_ptr !== (AW+1)'(m_rp) || bus.commit_ptr !== (AW+1)'(m_cp) ||
          bus.pkt_len !== (AW+1)'(exp_len) || bus.busy !== (m_mode != M_IDLE) ||
          bus.underrun !== m_unr || bus.protocol_err !== m_perr) begin
        n_fail++;
        $display("FAIL random%0d: got en=%0b addr=%0d rp=%0d cp=%0d len=%0d busy=%0b un=%0b pe=%0b, required %0b %0d %0d %0d %0d %0b %0b %0b",
                 i, bus.read_en, bus.read_addr, bus.read_ptr, bus.commit_ptr,
                 bus.pkt_len, bus.busy, bus.underrun, bus.protocol_err,
                 m_ren, m_addr, m_rp, m_cp, exp_len, (m_mode != M_IDLE),
                 m_unr, m_perr);
      end
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    test_basic_read();
    test_underrun();
    test_retry_replay();
    test_wrap();
    test_hold_ack_priority();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
